// File: rtl/frame_sync_pkg.sv
// Shared definitions for the frame-synchronisation controller.
//   fs_state_t : controller FSM states (HUNT, VERIFY, LOCK)
//   SYNC_WORD  : 4-bit frame sync word 1010, sent after each payload
//   SYNC_LEN   : sync word length in bits
package frame_sync_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } fs_state_t;

  localparam logic [3:0] SYNC_WORD = 4'b1010;
  localparam int         SYNC_LEN  = 4;

endpackage

// File: rtl/frame_sync_ctrl_det.sv
// Non-overlapping Mealy detector for the bit pattern 1010.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (returns to empty)
//   clr   : synchronous return to the empty state
//   en    : bit strobe; the detector only advances when en=1
//   x     : serial data bit
//   det   : combinational detect, high in the cycle the final 0 arrives with en=1
module sync_det_1010 (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic x,
  output logic det
);

  typedef enum logic [1:0] {
    D_EMPTY = 2'd0,
    D_1     = 2'd1,
    D_10    = 2'd2,
    D_101   = 2'd3
  } det_state_t;

  det_state_t st_q, st_d;

  // detector state register; clear has priority over advancing
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= D_EMPTY;
    end else if (clr) begin
      st_q <= D_EMPTY;
    end else begin
      st_q <= st_d;
    end
  end

  // next-state and Mealy detect output
  always_comb begin
    st_d = st_q;
    det  = 1'b0;
    if (en) begin
      case (st_q)
        D_EMPTY: st_d = x ? D_1 : D_EMPTY;
        D_1:     st_d = x ? D_1 : D_10;
        D_10:    st_d = x ? D_101 : D_EMPTY;
        D_101: begin
          if (x) begin
            // "1011": only the trailing 1 can start a new word
            st_d = D_1;
          end else begin
            // complete word: restart from empty (no overlap)
            det  = 1'b1;
            st_d = D_EMPTY;
          end
        end
        default: st_d = D_EMPTY;
      endcase
    end else begin
      st_d = st_q;
    end
  end

endmodule

// File: rtl/frame_sync_ctrl.sv
// Frame-synchronisation controller for frames [PAYLOAD_LEN payload][1010].
// Hunts for the sync word, verifies it at HIT_MIN consecutive frame
// positions, then delivers payload bits while locked; drops lock after
// MISS_MAX consecutive sync misses.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   x, bit_en    : serial bit and its strobe (everything holds when bit_en=0)
//   dout         : registered payload bit (holds between valid bits)
//   dout_valid   : pulse, dout carries a locked payload bit
//   frame_start  : pulse, sync confirmed in LOCK
//   sync_err     : pulse, sync mismatch in LOCK
//   locked       : level, FSM is in LOCK
// Optional (macro FRAME_SYNC_STATS_EN):
//   frames_ok    : saturating count of frame_start pulses
//   lock_losses  : saturating count of LOCK->HUNT transitions
module frame_sync_ctrl
  import frame_sync_pkg::*;
#(
  parameter int PAYLOAD_LEN = 8,
  parameter int HIT_MIN     = 2,
  parameter int MISS_MAX    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        x,
  input  logic        bit_en,
  output logic        dout,
  output logic        dout_valid,
  output logic        frame_start,
  output logic        sync_err,
  output logic        locked
`ifdef FRAME_SYNC_STATS_EN
  ,
  output logic [15:0] frames_ok,
  output logic [15:0] lock_losses
`endif
);

  localparam int FRAME_LEN = PAYLOAD_LEN + SYNC_LEN;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int HIT_W     = $clog2(HIT_MIN + 1);
  localparam int MISS_W    = $clog2(MISS_MAX + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0]  IDX_PAY   = IDX_W'(PAYLOAD_LEN);
  localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(HIT_MIN - 1);
  localparam logic [HIT_W-1:0]  HIT_FULL  = HIT_W'(HIT_MIN);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);

  fs_state_t              state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [HIT_W-1:0]       hits_q, hits_d;
  logic [MISS_W-1:0]      miss_q, miss_d;
  // Only the previous SYNC_LEN-1 bits are stored; the current bit
  // completes the 4-bit window, so a fourth stored bit is never read.
  logic [SYNC_LEN-2:0]    hist_q, hist_d;
  logic                   dout_q, dout_d;
  logic                   dout_valid_q, dout_valid_d;
  logic                   frame_start_q, frame_start_d;
  logic                   sync_err_q, sync_err_d;

  logic [SYNC_LEN-1:0]    win_s;
  logic                   sync_check_s;
  logic                   sync_ok_s;
  logic [IDX_W-1:0]       idx_next_s;
  logic                   det_s;

  assign win_s        = {hist_q, x};
  assign sync_check_s = (idx_q == IDX_LAST);
  assign sync_ok_s    = (win_s == SYNC_WORD);
  assign idx_next_s   = sync_check_s ? '0 : (idx_q + IDX_W'(1));

  // The shared detector is only meaningful while hunting; any other state
  // holds it cleared, so it is empty again whenever HUNT is re-entered.
  sync_det_1010 u_det (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != HUNT),
    .en    (bit_en),
    .x     (x),
    .det   (det_s)
  );

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HUNT;
      idx_q         <= '0;
      hits_q        <= '0;
      miss_q        <= '0;
      hist_q        <= '0;
      dout_q        <= 1'b0;
      dout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      hits_q        <= hits_d;
      miss_q        <= miss_d;
      hist_q        <= hist_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
    end
  end

  // next-state logic and pulse generation for one accepted bit
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    hits_d        = hits_q;
    miss_d        = miss_q;
    hist_d        = hist_q;
    dout_d        = dout_q;
    dout_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;
    if (bit_en) begin
      hist_d = win_s[SYNC_LEN-2:0];
      case (state_q)
        HUNT: begin
          idx_d = '0;
          if (det_s) begin
            hits_d  = HIT_W'(1);
            miss_d  = '0;
            state_d = (HIT_MIN == 1) ? LOCK : VERIFY;
          end else begin
            hits_d = '0;
          end
        end
        VERIFY: begin
          idx_d = idx_next_s;
          if (sync_check_s && sync_ok_s) begin
            if (hits_q >= HIT_LAST) begin
              hits_d  = HIT_FULL;
              miss_d  = '0;
              state_d = LOCK;
            end else begin
              hits_d = hits_q + HIT_W'(1);
            end
          end else if (sync_check_s) begin
            hits_d  = '0;
            idx_d   = '0;
            state_d = HUNT;
          end else begin
            hits_d = hits_q;
          end
        end
        LOCK: begin
          // idx free-runs through misses: no re-alignment while locked
          idx_d = idx_next_s;
          if (idx_q < IDX_PAY) begin
            dout_d       = x;
            dout_valid_d = 1'b1;
          end else if (sync_check_s && sync_ok_s) begin
            miss_d        = '0;
            frame_start_d = 1'b1;
          end else if (sync_check_s) begin
            sync_err_d = 1'b1;
            if (miss_q >= MISS_LAST) begin
              miss_d  = '0;
              hits_d  = '0;
              idx_d   = '0;
              state_d = HUNT;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end else begin
            miss_d = miss_q;
          end
        end
        default: begin
          state_d = HUNT;
          idx_d   = '0;
        end
      endcase
    end else begin
      hist_d = hist_q;
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign frame_start = frame_start_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == LOCK);

`ifdef FRAME_SYNC_STATS_EN
  logic [15:0] frames_ok_q;
  logic [15:0] lock_losses_q;

  // saturating statistics counters
  always_ff @(posedge clk) begin
    if (reset) begin
      frames_ok_q   <= 16'h0000;
      lock_losses_q <= 16'h0000;
    end else begin
      if (frame_start_d && (frames_ok_q != 16'hFFFF)) begin
        frames_ok_q <= frames_ok_q + 16'h0001;
      end
      if ((state_q == LOCK) && (state_d == HUNT) && (lock_losses_q != 16'hFFFF)) begin
        lock_losses_q <= lock_losses_q + 16'h0001;
      end
    end
  end

  assign frames_ok   = frames_ok_q;
  assign lock_losses = lock_losses_q;
`endif

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Table-driven bench for frame_sync_ctrl with default parameters
// (PAYLOAD_LEN=8, FRAME_LEN=12, HIT_MIN=2, MISS_MAX=2).
// Each record holds one cycle of inputs and the outputs expected one
// clock later: {dout, dout_valid, frame_start, sync_err, locked}.
module tb_frame_sync_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic x;
  logic bit_en;
  logic dout;
  logic dout_valid;
  logic frame_start;
  logic sync_err;
  logic locked;

  frame_sync_ctrl #(
    .PAYLOAD_LEN (8),
    .HIT_MIN     (2),
    .MISS_MAX    (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .bit_en      (bit_en),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .frame_start (frame_start),
    .sync_err    (sync_err),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       xv;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_dout = 1'b0;
  bit   sparse   = 1'b0;

  // one table record; tracks the held dout value
  task automatic push1(input logic rst, input logic en, input logic xv,
                       input logic dv, input logic fs, input logic se, input logic lk);
    vec_t v;
    if (rst) exp_dout = 1'b0;
    else if (dv) exp_dout = xv;
    v.rst = rst;
    v.en  = en;
    v.xv  = xv;
    v.exp = {exp_dout, dv, fs, se, lk};
    vecs.push_back(v);
  endtask

  // one strobed bit, followed by two idle cycles in 1/3-duty mode
  task automatic bitv(input logic xv, input logic dv, input logic fs,
                      input logic se, input logic lk);
    push1(1'b0, 1'b1, xv, dv, fs, se, lk);
    if (sparse) begin
      for (int k = 0; k < 2; k++) push1(1'b0, 1'b0, ~xv, 1'b0, 1'b0, 1'b0, lk);
    end
  endtask

  // n bits (MSB first) that produce no pulses
  task automatic quiet(input logic [11:0] bits, input int n, input logic lk);
    for (int i = n - 1; i >= 0; i--) bitv(bits[i], 1'b0, 1'b0, 1'b0, lk);
  endtask

  // 8 payload bits while locked: each gives dout_valid
  task automatic payload(input logic [7:0] p);
    for (int i = 7; i >= 0; i--) bitv(p[i], 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  // 4 sync-position bits while locked; last one is checked
  task automatic sync_lk(input logic [3:0] s, input logic lk_after);
    logic ok;
    ok = (s == 4'b1010);
    for (int i = 3; i >= 1; i--) bitv(s[i], 1'b0, 1'b0, 1'b0, 1'b1);
    bitv(s[0], 1'b0, ok, ~ok, lk_after);
  endtask

  // from HUNT: detect, one verified frame, locked after the 2nd sync
  task automatic acquire(input logic [7:0] p);
    quiet(12'b1010, 4, 1'b0);
    quiet({4'b0000, p}, 8, 1'b0);
    quiet(12'b101, 3, 1'b0);
    bitv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [4:0] got;
    reset  = 1'b1;
    bit_en = 1'b0;
    x      = 1'b0;

    // lock acquisition, then a clean locked frame
    acquire(8'hC3);
    payload(8'h5A);
    sync_lk(4'b1010, 1'b1);
    // single corrupted sync keeps lock, good sync clears miss
    payload(8'h96);
    sync_lk(4'b1110, 1'b1);
    payload(8'h3C);
    sync_lk(4'b1010, 1'b1);
    // a lone miss after the clear must still keep lock
    payload(8'hF0);
    sync_lk(4'b1110, 1'b1);
    // second consecutive miss drops lock
    payload(8'h0F);
    sync_lk(4'b0010, 1'b0);
    quiet(12'h000, 12, 1'b0);
    // HUNT on 101010, then a bad sync in VERIFY returns to HUNT
    quiet(12'b101010, 6, 1'b0);
    quiet(12'b011001, 6, 1'b0);
    quiet(12'b0000, 4, 1'b0);
    acquire(8'h00);
    payload(8'hE7);
    sync_lk(4'b1010, 1'b1);
    // reset in the middle of a locked payload
    bitv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    bitv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    bitv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    push1(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    acquire(8'h5A);
    payload(8'h81);
    sync_lk(4'b1010, 1'b1);
    // same traffic with bit_en at 1/3 duty
    push1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sparse = 1'b1;
    acquire(8'hC3);
    payload(8'h5A);
    sync_lk(4'b1010, 1'b1);
    payload(8'h96);
    sync_lk(4'b1110, 1'b1);
    sparse = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    got = {dout, dout_valid, frame_start, sync_err, locked};
    checks++;
    if (got !== 5'b00000) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", got, 5'b00000);
    end

    // idle after reset: nothing may change without a strobe
    @(negedge clk);
    reset  = 1'b0;
    bit_en = 1'b0;
    x      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got = {dout, dout_valid, frame_start, sync_err, locked};
    checks++;
    if (got !== 5'b00000) begin
      errors++;
      $display("FAIL idle_hold got=%b exp=%b", got, 5'b00000);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset  = vecs[i].rst;
      bit_en = vecs[i].en;
      x      = vecs[i].xv;
      @(posedge clk);
      #1;
      got = {dout, dout_valid, frame_start, sync_err, locked};
      checks++;
      if (got !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec%0d {dout,dv,fs,se,lk} got=%b exp=%b", i, got, vecs[i].exp);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_sync_ctrl.md
# frame_sync_ctrl

Frame-synchronisation controller for a serial bit stream carrying frames of the form [PAYLOAD_LEN payload bits][sync word 1010]. It hunts for the 4-bit sync word with a non-overlapping detector, then confirms sync at the expected frame positions before declaring lock. While locked it delivers payload bits, and it drops lock after repeated sync misses. It sits between the serial receive front end and the payload deserialiser, and sequences the shared 1010 detector.

## Interface
- PAYLOAD_LEN, 8: payload bits per frame (≥1); FRAME_LEN = PAYLOAD_LEN + 4
- HIT_MIN, 2: consecutive confirmed sync words needed to enter LOCK (≥1)
- MISS_MAX, 2: consecutive missed sync words in LOCK that force HUNT (≥1)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- x  input  1  serial data bit, sampled only when bit_en=1
- bit_en  input  1  bit strobe; when 0, all state holds and pulses stay 0
- dout  output  1  registered payload bit
- dout_valid  output  1  one-cycle pulse: dout holds a locked payload bit
- frame_start  output  1  one-cycle pulse: sync confirmed in LOCK, next bit is payload index 0
- sync_err  output  1  one-cycle pulse: sync mismatch while in LOCK
- locked  output  1  level, 1 while the FSM is in LOCK

## Operation
- FSM states: HUNT, VERIFY, LOCK.
- Bit counter idx counts 0..FRAME_LEN-1. Positions 0..PAYLOAD_LEN-1 are payload and PAYLOAD_LEN..FRAME_LEN-1 are sync. idx wraps to 0 after FRAME_LEN-1.
- A 4-bit shift register collects x on every bit_en. A sync check is made at idx = FRAME_LEN-1, using the shift register value including the current bit, compared against 4'b1010.
- HUNT: the detector runs on every bit_en. It is a Mealy machine and is non-overlapping: after a detect it restarts from empty, so the stream 1010 10 gives exactly one detect. On a detect: go to VERIFY, set idx=0 for the next bit, set hits=1.
- VERIFY: the detector is held cleared. On a sync check:
  - Match: hits+1. If hits reaches HIT_MIN, go to LOCK with miss=0. Otherwise stay in VERIFY.
  - Mismatch: go to HUNT and clear the detector.
  - If HIT_MIN=1, the first detect goes straight to LOCK.
- LOCK: each payload-position bit produces dout=x and dout_valid=1. On a sync check:
  - Match: miss=0 and frame_start=1.
  - Mismatch: sync_err=1 and miss+1. If miss reaches MISS_MAX, go to HUNT, set locked=0 and clear the detector. Otherwise stay in LOCK and keep delivering payload.
- idx keeps counting through misses; the controller never re-aligns while in LOCK.
- hits and miss saturate at their thresholds and have width $clog2(max+1).

## Timing
- All outputs are registered. For a bit presented with bit_en in cycle n, its outputs appear in cycle n+1.
- Reset values: dout=0, dout_valid=0, frame_start=0, sync_err=0, locked=0. Reset also sets state=HUNT, idx=0, hits=0, miss=0, clears the shift register and clears the detector.
- Reset mid-frame: everything above is cleared on the next clock edge; no pulses are emitted in that cycle.
- Pulses are at most one cycle per accepted bit. With bit_en=0, dout holds its value and all pulses are 0.
- locked rises in the cycle after the HIT_MIN-th confirming bit. It falls in the cycle after the MISS_MAX-th missing bit.
- Pulse coincidences:
  - sync_err and frame_start are mutually exclusive.
  - dout_valid never coincides with either of them.

## Configuration
- FRAME_SYNC_STATS_EN defined: adds two output ports.
  - frames_ok [15:0]: counts frame_start pulses.
  - lock_losses [15:0]: counts LOCK→HUNT transitions.
  - Both counters saturate at 16'hFFFF and reset to 0.
- FRAME_SYNC_STATS_EN not defined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Package frame_sync_pkg holds:
  - state enum fs_state_t {HUNT, VERIFY, LOCK}
  - SYNC_WORD = 4'b1010
  - SYNC_LEN = 4
- Sub-module sync_det_1010:
  - Ports clk, reset, clr, en, x, det.
  - Non-overlapping Mealy 1010 detector.
  - det is combinational and qualified by en.
  - clr is a synchronous return to the empty state.

## Test plan
All scenarios use defaults (FRAME_LEN=12).
- Reset mid-LOCK: assert reset for 1 cycle → all outputs 0 and state HUNT next cycle; a subsequent clean stream relocks after exactly 2 frames.
- Stream 1010 + 8 payload + 1010 → locked=1 one cycle after the 2nd sync. The next frame's 8 payload bits appear on dout with 8 dout_valid pulses, followed by frame_start.
- Locked, then one corrupted sync (1110) → sync_err pulse and locked stays 1. Next good sync → frame_start and miss cleared.
- Locked, then two consecutive corrupted syncs → two sync_err pulses and locked=0 after the second. No dout_valid afterwards.
- HUNT on 101010 → exactly one detect (non-overlap). A mismatching sync in VERIFY → back to HUNT with locked never asserted.
- bit_en toggled at 1/3 duty with the same stream → identical outputs to the continuous-strobe case, spread out in time; pulses only in the cycle after a strobe.
